// File: rtl/dco_pkg.sv
// Shared types, default parameter values and the saturating clamp used by the
// DCO code controller.
package dco_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLEW = 2'd1,
        LOCK = 2'd2,
        HOLD = 2'd3
    } dco_state_e;

    localparam int DCO_N_CELLS_DEF  = 129;
    localparam int DCO_INT_W_DEF    = 8;
    localparam int DCO_FRAC_W_DEF   = 4;
    localparam int DCO_SLEW_MAX_DEF = 8;

    function automatic int unsigned dco_clamp(input int unsigned val, input int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/dco_therm_enc.sv
// Binary-to-thermometer encoder: bit i of code_o is set exactly when i < level_i.
module dco_therm_enc
    import dco_pkg::*;
#(
    parameter int N_CELLS = DCO_N_CELLS_DEF,
    parameter int INT_W   = DCO_INT_W_DEF
) (
    input  logic [INT_W-1:0]   level_i,
    output logic [N_CELLS-1:0] code_o
);

    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            code_o[i] = (i < int'(level_i));
        end
    end

endmodule

// File: rtl/dco_code_ctrl.sv
// DCO code controller: slew-limited move of a thermometer cell code toward an accepted
// tune word, with hold freeze. Define DCO_DITHER_EN to add first-order fractional dither.
module dco_code_ctrl
    import dco_pkg::*;
#(
    parameter int N_CELLS  = DCO_N_CELLS_DEF,
    parameter int INT_W    = DCO_INT_W_DEF,
    parameter int FRAC_W   = DCO_FRAC_W_DEF,
    parameter int SLEW_MAX = DCO_SLEW_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_W-1:0]   tune_int,
    input  logic [FRAC_W-1:0]  tune_frac,
    input  logic               tune_valid,
    output logic               tune_ready,
    input  logic               hold,
    output logic [N_CELLS-1:0] code,
    output logic [INT_W-1:0]   level,
    output logic               settled
);

    localparam logic [INT_W-1:0] SLEW_MAX_C = INT_W'(SLEW_MAX);

    dco_state_e         state_q, state_d, prior_q, prior_d;
    logic [INT_W-1:0]   tgt_int_q, tgt_int_d;
    logic [INT_W-1:0]   level_q, level_d;
    logic [N_CELLS-1:0] code_q, code_d;
    logic               settled_q, ready_q;

    logic               accept_c, load_c, new_tgt_c, up_c;
    logic [INT_W-1:0]   in_int_c, diff_c, step_c, slew_lvl_c, lock_lvl_c;

`ifdef DCO_DITHER_EN
    localparam logic [INT_W-1:0] N_CELLS_C = INT_W'(N_CELLS);
    localparam logic [INT_W-1:0] ONE_C     = INT_W'(1);

    logic [FRAC_W-1:0]  tgt_frac_q, tgt_frac_d, acc_q, acc_d, in_frac_c;
    logic [FRAC_W:0]    acc_sum_c;
`else
    logic               frac_unused;
    assign frac_unused = ^tune_frac;
`endif

    always_comb begin
        // hold wins over a simultaneous tune_valid
        accept_c = tune_valid && ready_q && !hold;
        in_int_c = INT_W'(dco_clamp(32'(tune_int), 32'(N_CELLS)));

        up_c       = (tgt_int_q >= level_q);
        diff_c     = up_c ? (tgt_int_q - level_q) : (level_q - tgt_int_q);
        step_c     = (diff_c > SLEW_MAX_C) ? SLEW_MAX_C : diff_c;
        slew_lvl_c = up_c ? (level_q + step_c) : (level_q - step_c);

`ifdef DCO_DITHER_EN
        in_frac_c  = (in_int_c != tune_int) ? '0 : tune_frac;
        new_tgt_c  = (in_int_c != tgt_int_q) || (in_frac_c != tgt_frac_q);
        acc_sum_c  = {1'b0, acc_q} + {1'b0, tgt_frac_q};
        lock_lvl_c = (acc_sum_c[FRAC_W] && (tgt_int_q != N_CELLS_C)) ? (tgt_int_q + ONE_C) : tgt_int_q;
        tgt_frac_d = tgt_frac_q;
        acc_d      = acc_q;
`else
        new_tgt_c  = (in_int_c != tgt_int_q);
        lock_lvl_c = tgt_int_q;
`endif

        state_d   = state_q;
        prior_d   = prior_q;
        tgt_int_d = tgt_int_q;
        level_d   = level_q;
        load_c    = 1'b0;

        if (hold) begin
            if (state_q != HOLD) begin
                prior_d = state_q;
                state_d = HOLD;
            end
        end else begin
            case (state_q)
                IDLE: load_c = accept_c;
                SLEW: begin
                    level_d = slew_lvl_c;
                    if (slew_lvl_c == tgt_int_q) begin
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (accept_c && new_tgt_c) begin
                        load_c = 1'b1;
                    end else begin
                        level_d = lock_lvl_c;
`ifdef DCO_DITHER_EN
                        acc_d   = acc_sum_c[FRAC_W-1:0];
`endif
                    end
                end
                HOLD:    state_d = prior_q;
                default: state_d = IDLE;
            endcase
        end

        // a new target restarts the slew from the current level
        if (load_c) begin
            tgt_int_d = in_int_c;
            state_d   = SLEW;
`ifdef DCO_DITHER_EN
            tgt_frac_d = in_frac_c;
            acc_d      = '0;
`endif
        end
    end

    dco_therm_enc #(
        .N_CELLS (N_CELLS),
        .INT_W   (INT_W)
    ) u_therm (
        .level_i (level_d),
        .code_o  (code_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prior_q    <= IDLE;
            tgt_int_q  <= '0;
            level_q    <= '0;
            code_q     <= '0;
            settled_q  <= 1'b0;
            ready_q    <= 1'b0;
`ifdef DCO_DITHER_EN
            tgt_frac_q <= '0;
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prior_q    <= prior_d;
            tgt_int_q  <= tgt_int_d;
            level_q    <= level_d;
            code_q     <= code_d;
            settled_q  <= (state_d == LOCK);
            ready_q    <= (state_d == IDLE) || (state_d == LOCK);
`ifdef DCO_DITHER_EN
            tgt_frac_q <= tgt_frac_d;
            acc_q      <= acc_d;
`endif
        end
    end

    assign code       = code_q;
    assign level      = level_q;
    assign settled    = settled_q;
    assign tune_ready = ready_q;

endmodule

// File: tb/tb_dco_code_ctrl.sv
// Scoreboard bench for dco_code_ctrl: a trajectory-level reference model pushes the
// expected outputs each clock and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_dco_code_ctrl;

    localparam int N  = 129;
    localparam int IW = 8;
    localparam int FW = 4;
    localparam int SM = 8;
    localparam logic [N-1:0] ALL1 = '1;
    localparam int MD_IDLE = 0;
    localparam int MD_SLEW = 1;
    localparam int MD_LOCK = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] tune_int;
    logic [FW-1:0] tune_frac;
    logic          tune_valid;
    logic          tune_ready;
    logic          hold;
    logic [N-1:0]  code;
    logic [IW-1:0] level;
    logic          settled;

    always #5 clk = ~clk;

    dco_code_ctrl #(
        .N_CELLS  (N),
        .INT_W    (IW),
        .FRAC_W   (FW),
        .SLEW_MAX (SM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tune_int   (tune_int),
        .tune_frac  (tune_frac),
        .tune_valid (tune_valid),
        .tune_ready (tune_ready),
        .hold       (hold),
        .code       (code),
        .level      (level),
        .settled    (settled)
    );

    typedef struct {
        logic [N-1:0] code;
        int           level;
        bit           settled;
        bit           ready;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic check_code(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: on an accepted new target the whole level trajectory is
    // precomputed; each unfrozen slew clock consumes one entry.
    int  m_level, m_tgt, m_mode;
    bit  m_frozen, m_ready, m_settled;
    int  traj[$];
    int  ci, t_l, t_d;
    bit  acc_ok, differs;
`ifdef DCO_DITHER_EN
    int  m_tgtf, m_acc, cf;
`endif

    always @(posedge clk) begin : model
        exp_t e;
        if (!rst) begin
            m_level  = 0;
            m_tgt    = 0;
            m_mode   = MD_IDLE;
            m_frozen = 0;
            traj.delete();
`ifdef DCO_DITHER_EN
            m_tgtf   = 0;
            m_acc    = 0;
`endif
            m_ready   = 0;
            m_settled = 0;
        end else begin
            if (hold) begin
                m_frozen = 1;
            end else if (m_frozen) begin
                m_frozen = 0;
            end else begin
                acc_ok  = tune_valid && m_ready;
                ci      = (int'(tune_int) > N) ? N : int'(tune_int);
                differs = (ci != m_tgt);
`ifdef DCO_DITHER_EN
                cf      = (int'(tune_int) > N) ? 0 : int'(tune_frac);
                differs = differs || (cf != m_tgtf);
`endif
                if (acc_ok && (m_mode == MD_IDLE || differs)) begin
                    traj.delete();
                    t_l = m_level;
                    do begin
                        t_d = ci - t_l;
                        if (t_d > SM) t_l = t_l + SM;
                        else if (t_d < -SM) t_l = t_l - SM;
                        else t_l = ci;
                        traj.push_back(t_l);
                    end while (t_l != ci);
                    m_tgt  = ci;
                    m_mode = MD_SLEW;
`ifdef DCO_DITHER_EN
                    m_tgtf = cf;
                    m_acc  = 0;
`endif
                end else if (m_mode == MD_SLEW) begin
                    m_level = traj.pop_front();
                    if (traj.size() == 0) m_mode = MD_LOCK;
                end else if (m_mode == MD_LOCK) begin
`ifdef DCO_DITHER_EN
                    m_acc = m_acc + m_tgtf;
                    if (m_acc >= (1 << FW)) begin
                        m_acc   = m_acc - (1 << FW);
                        m_level = (m_tgt + 1 > N) ? N : m_tgt + 1;
                    end else begin
                        m_level = m_tgt;
                    end
`else
                    m_level = m_tgt;
`endif
                end
            end
            m_ready   = !m_frozen && (m_mode == MD_IDLE || m_mode == MD_LOCK);
            m_settled = !m_frozen && (m_mode == MD_LOCK);
        end
        e.level   = m_level;
        e.code    = ALL1 >> (N - m_level);
        e.settled = m_settled;
        e.ready   = m_ready;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: no expected entry for level %0d", level);
        end else begin
            e = exp_q.pop_front();
            check_int("sb_level", int'(level), e.level);
            check_code("sb_code", code, e.code);
            check_int("sb_settled", int'(settled), int'(e.settled));
            check_int("sb_ready", int'(tune_ready), int'(e.ready));
        end
    end

    // Caller is positioned at a negedge.
    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        check_int("rst_code_zero", int'(code != '0), 0);
        check_int("rst_level", int'(level), 0);
        check_int("rst_settled", int'(settled), 0);
        check_int("rst_ready", int'(tune_ready), 0);
        repeat (2) begin
            @(negedge clk);
            tune_int   = IW'($urandom);
            tune_frac  = FW'($urandom);
            tune_valid = 1'($urandom);
            hold       = 1'($urandom);
        end
        @(negedge clk);
        tune_valid = 1'b0;
        hold       = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check_int("ready_after_release", int'(tune_ready), 1);
    endtask

    task automatic do_accept(input int ti, input int tf);
        int n;
        n = 0;
        tune_valid = 1'b0;
        hold       = 1'b0;
        while (tune_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (tune_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tune_ready=%b, required 1", tune_ready);
        end
        tune_int   = IW'(ti);
        tune_frac  = FW'(tf);
        tune_valid = 1'b1;
        @(negedge clk);
        tune_valid = 1'b0;
    endtask

    task automatic wait_settled(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (settled !== 1'b1 && k < 300);
        if (settled !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout: settled=%b after %0d clocks, required 1", settled, k);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k, n, n41, nset;
        rst        = 1'b0;
        hold       = 1'b0;
        tune_valid = 1'b0;
        tune_int   = '0;
        tune_frac  = '0;
        @(negedge clk);
        do_reset();

        // full-range slew from 0
        do_accept(129, 0);
        wait_settled(k);
        check_int("full_slew_clocks", k, 17);
        check_int("full_slew_level", int'(level), 129);

        // clamp of an out-of-range tune word
        do_reset();
        do_accept(200, 5);
        wait_settled(k);
        check_int("clamp_level", int'(level), 129);
        check_code("clamp_code_all_ones", code, ALL1);

        // hold during a slew
        do_reset();
        do_accept(100, 0);
        repeat (3) @(negedge clk);
        check_int("hold_pre_level", int'(level), 24);
        hold = 1'b1;
        repeat (4) @(negedge clk);
        check_int("hold_frozen_level", int'(level), 24);
        check_int("hold_ready", int'(tune_ready), 0);
        hold = 1'b0;
        wait_settled(k);
        check_int("hold_resume_level", int'(level), 100);

        // reset in the middle of a slew
        do_reset();
        do_accept(129, 0);
        n = 0;
        while (level != 56 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_int("midrst_reach_56", int'(level), 56);
        do_reset();
        check_int("midrst_idle_level", int'(level), 0);
        check_int("midrst_idle_settled", int'(settled), 0);

`ifdef DCO_DITHER_EN
        do_accept(40, 4);
        wait_settled(k);
        n41  = 0;
        nset = 0;
        repeat (16) begin
            @(negedge clk);
            if (level == 41) n41++;
            if (settled == 1'b1) nset++;
        end
        check_int("dither_high_count", n41, 4);
        check_int("dither_settled_count", nset, 16);
`endif

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                hold       = ($urandom_range(0, 9) == 0);
                tune_valid = ($urandom_range(0, 1) == 1);
                tune_int   = IW'($urandom_range(0, 255));
                tune_frac  = FW'($urandom);
            end
        end
        hold       = 1'b0;
        tune_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dco_code_ctrl.md
DCO_CODE_CTRL -- requirements
Module: dco_code_ctrl

Interface
REQ-001 SHALL have parameter N_CELLS, default 129, meaning the number of DCO delay cells and the thermometer width.
REQ-002 SHALL have parameter INT_W, default 8, meaning the integer tune-word width, with 2**INT_W > N_CELLS.
REQ-003 SHALL have parameter FRAC_W, default 4, meaning the fractional tune-word width.
REQ-004 SHALL have parameter SLEW_MAX, default 8, meaning the maximum change in active cells per clock, with 1 <= SLEW_MAX <= N_CELLS.
REQ-005 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: tune_int input INT_W, target cell count; tune_frac input FRAC_W, target fraction; tune_valid input 1; tune_ready output 1.
REQ-007 SHALL have ports: hold input 1, freezes the output; code output N_CELLS, thermometer code; level output INT_W, binary count of ones in code; settled output 1.

Function
REQ-008 SHALL accept a tune word only on a clk edge where tune_valid and tune_ready are both high; a word accepted there becomes the target.
REQ-009 SHALL clamp an accepted tune_int above N_CELLS to N_CELLS, and SHALL force tune_frac to 0 when the clamp applies.
REQ-010 SHALL implement states IDLE, SLEW, LOCK, HOLD.
- IDLE: after reset; accept -> SLEW.
- SLEW: level moves toward target.int by min(|diff|, SLEW_MAX) per clock; level == target.int -> LOCK.
- LOCK: an accept with a new target -> SLEW; the same target stays in LOCK.
- HOLD: entered from any state when hold=1; returns to the prior state on the first clock with hold=0.
REQ-011 SHALL drive tune_ready=1 in IDLE and LOCK and 0 in SLEW and HOLD.
REQ-012 SHALL drive settled=1 only in LOCK.
REQ-013 SHALL freeze code, level and the dither accumulator in HOLD.
REQ-014 SHALL register code, level and settled, with code equal to the thermometer of level (bits [level-1:0] set) in the same cycle.
REQ-015 SHALL update the output one clock after the accept edge, giving a first step one clock after acceptance.
REQ-016 SHALL, after a full-range step from 0 to N_CELLS with defaults, reach LOCK in ceil(129/8)=17 clocks after the accept.
REQ-017 SHALL treat hold and tune_valid asserted together as hold taking priority, with no accept on that edge.

Reset
REQ-018 SHALL, while rst=0, drive code=0, level=0, settled=0, tune_ready=0, with target and accumulator set to 0 and state IDLE, independent of clk.
REQ-019 SHALL drive tune_ready=1 on the first clk edge after rst deasserts.
REQ-020 SHALL abort a slew in progress when reset is asserted mid-slew, with no residual state kept.

Configuration
REQ-021 SHALL use macro DCO_DITHER_EN to compile the dither feature in or out.
REQ-022 SHALL, with DCO_DITHER_EN defined and in LOCK, run a first-order FRAC_W-bit accumulator adding target.frac each clock; the carry out adds 1 to level for that clock, saturating at N_CELLS.
REQ-023 SHALL, with DCO_DITHER_EN defined, hold the dithered level within {target.int, target.int+1}, with settled remaining 1.
REQ-024 SHALL, with DCO_DITHER_EN undefined, ignore tune_frac, omit the accumulator, and make level exactly target.int in LOCK.

Structure
REQ-025 SHALL place in shared package dco_pkg: the state enum type, default-parameter constants, and the saturating clamp function.
REQ-026 SHALL implement the binary-to-thermometer conversion in sub-module dco_therm_enc, combinational and parametrised by N_CELLS.

Verification
REQ-027 SHALL cover reset: rst=0 with random inputs -> code=0, level=0, settled=0, tune_ready=0; first edge after release -> tune_ready=1.
REQ-028 SHALL cover a full-range slew: accept 129 from level 0 -> level 8,16,...,128,129; settled=1 at clock 17; tune_ready=0 throughout.
REQ-029 SHALL cover the clamp: accept tune_int=200, tune_frac=5 -> target 129, frac 0; code all ones after the slew.
REQ-030 SHALL cover dither with DCO_DITHER_EN defined: accept tune_int=40, tune_frac=4 (0.25) -> level=41 on exactly 4 of every 16 LOCK clocks, otherwise 40.
REQ-031 SHALL cover mid-slew hold: accept 100 from 0, hold=1 after 3 clocks -> level frozen at 24; hold=0 -> slew resumes to 100.
REQ-032 SHALL cover mid-slew reset: rst low at level 56 while slewing -> code=0 immediately; state IDLE on release.
